// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Owns the program counter and sequences instruction fetch. It issues one
// req/ack read at a time to instruction memory, buffers the returned
// instruction for decode under a valid/ready handshake, and redirects the PC
// on branch, trap or halt.
//
// Parameters
//   XLEN          PC / address width
//   RESET_VECTOR  PC value loaded on reset
//   TRAP_VECTOR   PC loaded on trap
//   ILEN          instruction width
//
// Ports
//   clk            in   rising-edge clock
//   reset_n        in   asynchronous active-low reset
//   imem_req       out  fetch request, held high until imem_ack
//   imem_addr      out  fetch address, stable while imem_req is high
//   imem_ack       in   fetch complete, imem_rdata valid this cycle
//   imem_rdata     in   fetched instruction
//   instr_valid    out  buffered instruction valid to decode
//   instr          out  buffered instruction
//   instr_pc       out  PC of the buffered instruction
//   instr_ready    in   decode accepts instr this cycle
//   branch_taken   in   redirect request (1-cycle pulse)
//   branch_target  in   redirect address
//   trap           in   trap request (1-cycle pulse)
//   trap_pc        in   PC of the trapping instruction
//   epc            out  captured trap_pc
//   halt           in   stop fetching (level or pulse)
//   misalign_err   out  sticky: a redirect target was not 4-byte aligned
//   state          out  FSM state (00 IDLE, 01 FETCH, 10 HOLD, 11 HALTED)
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int unsigned     XLEN         = 64,
    parameter logic [XLEN-1:0] RESET_VECTOR = 64'h0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 64'h100,
    parameter int unsigned     ILEN         = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [ILEN-1:0] imem_rdata,
    output logic            instr_valid,
    output logic [ILEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            trap,
    input  logic [XLEN-1:0] trap_pc,
    output logic [XLEN-1:0] epc,
    input  logic            halt,
    output logic            misalign_err,
    output logic [1:0]      state
);

    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_FETCH  = 2'b01;
    localparam logic [1:0] S_HOLD   = 2'b10;
    localparam logic [1:0] S_HALTED = 2'b11;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic [1:0]      state_q,       state_d;
    logic [XLEN-1:0] pc_q,          pc_d;
    logic [XLEN-1:0] addr_q,        addr_d;
    logic            req_q,         req_d;
    logic            drop_q,        drop_d;
    logic            halt_pend_q,   halt_pend_d;
    logic            valid_q,       valid_d;
    logic [ILEN-1:0] instr_q,       instr_d;
    logic [XLEN-1:0] instr_pc_q,    instr_pc_d;
    logic [XLEN-1:0] epc_q,         epc_d;
    logic            mis_q,         mis_d;

    logic            redirect;
    logic [XLEN-1:0] target;
    logic            tgt_misaligned;
    logic            redirect_ok;
    logic [XLEN-1:0] pc_redir;
    logic            handshake;
    logic            ack_now;
    logic            stop_now;

    // Redirect resolution: trap wins over branch. A misaligned target is
    // never written into the PC; it stops the sequencer instead, so pc_redir
    // falls back to the current PC in that case.
    always_comb begin
        redirect       = trap | branch_taken;
        target         = trap ? TRAP_VECTOR : branch_target;
        tgt_misaligned = redirect && (target[1:0] != 2'b00);
        redirect_ok    = redirect && !tgt_misaligned;
        pc_redir       = redirect_ok ? target : pc_q;
        handshake      = valid_q && instr_ready;
        ack_now        = req_q && imem_ack;
        // A halt seen during an outstanding fetch is remembered in
        // halt_pend_q, since halt may be a single-cycle pulse.
        stop_now       = halt || halt_pend_q || tgt_misaligned;
    end

    // Next-state logic. In FETCH, req_q distinguishes a request in flight
    // (req_q=1) from the one-cycle gap after an ack whose data was thrown
    // away (req_q=0); the gap keeps imem_req from changing address while high.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        addr_d      = addr_q;
        req_d       = req_q;
        drop_d      = drop_q;
        halt_pend_d = halt_pend_q;
        valid_d     = valid_q;
        instr_d     = instr_q;
        instr_pc_d  = instr_pc_q;
        epc_d       = epc_q;
        mis_d       = mis_q;

        // epc is captured on every trap, even once halted.
        if (trap) begin
            epc_d = trap_pc;
        end

        if (tgt_misaligned && (state_q != S_HALTED)) begin
            mis_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                pc_d = pc_redir;
                if (stop_now) begin
                    state_d = S_HALTED;
                end else begin
                    state_d = S_FETCH;
                    req_d   = 1'b1;
                    addr_d  = pc_redir;
                end
            end

            S_FETCH: begin
                if (req_q) begin
                    if (ack_now) begin
                        req_d       = 1'b0;
                        drop_d      = 1'b0;
                        halt_pend_d = 1'b0;
                        if (stop_now) begin
                            pc_d    = pc_redir;
                            state_d = S_HALTED;
                        end else if (drop_q || redirect_ok) begin
                            // Data belongs to a path that was redirected away.
                            pc_d = pc_redir;
                        end else begin
                            instr_d    = imem_rdata;
                            instr_pc_d = pc_q;
                            valid_d    = 1'b1;
                            pc_d       = pc_q + PC_STEP;
                            state_d    = S_HOLD;
                        end
                    end else begin
                        // The memory request cannot be aborted, so a redirect
                        // or stop only takes effect when its ack returns.
                        pc_d = pc_redir;
                        if (redirect_ok) begin
                            drop_d = 1'b1;
                        end
                        if (stop_now) begin
                            halt_pend_d = 1'b1;
                        end
                    end
                end else begin
                    pc_d = pc_redir;
                    if (stop_now) begin
                        state_d = S_HALTED;
                    end else begin
                        req_d  = 1'b1;
                        addr_d = pc_redir;
                    end
                end
            end

            S_HOLD: begin
                pc_d = pc_redir;
                if (stop_now) begin
                    valid_d = 1'b0;
                    state_d = S_HALTED;
                end else if (redirect_ok || handshake) begin
                    valid_d = 1'b0;
                    state_d = S_FETCH;
                    req_d   = 1'b1;
                    addr_d  = pc_redir;
                end
            end

            default: begin
                // HALTED: only reset_n leaves this state.
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_VECTOR;
            addr_q      <= RESET_VECTOR;
            req_q       <= 1'b0;
            drop_q      <= 1'b0;
            halt_pend_q <= 1'b0;
            valid_q     <= 1'b0;
            instr_q     <= '0;
            instr_pc_q  <= '0;
            epc_q       <= '0;
            mis_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            req_q       <= req_d;
            drop_q      <= drop_d;
            halt_pend_q <= halt_pend_d;
            valid_q     <= valid_d;
            instr_q     <= instr_d;
            instr_pc_q  <= instr_pc_d;
            epc_q       <= epc_d;
            mis_q       <= mis_d;
        end
    end

    assign imem_req     = req_q;
    assign imem_addr    = addr_q;
    assign instr_valid  = valid_q;
    assign instr        = instr_q;
    assign instr_pc     = instr_pc_q;
    assign epc          = epc_q;
    assign misalign_err = mis_q;
    assign state        = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//
// Directed scenarios followed by a randomized run of pc_sequencer. Expected
// values come from a transaction-level reference: an architectural PC, the one
// outstanding fetch (with a "stale" mark once a redirect overtakes it), the
// instruction waiting at decode, and sticky halt / misalignment flags.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam logic [63:0] RV = 64'h0;
    localparam logic [63:0] TV = 64'h100;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic        branch_taken = 1'b0;
    logic [63:0] branch_target = '0;
    logic        trap = 1'b0;
    logic [63:0] trap_pc = '0;
    logic [63:0] epc;
    logic        halt = 1'b0;
    logic        misalign_err;
    logic [1:0]  state;

    always #5 clk = ~clk;

    pc_sequencer #(
        .XLEN(64), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .ILEN(32)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .trap(trap), .trap_pc(trap_pc), .epc(epc),
        .halt(halt), .misalign_err(misalign_err), .state(state)
    );

    int nCompared = 0;
    int nMismatched = 0;

    // Reference state.
    logic [63:0] mPc, mOutAddr, mInstrPc, mEpc;
    logic [31:0] mInstr;
    bit          mOut, mStale, mHolding, mHalted, mHaltPend, mMis;
    int          mDelivered;
    int          gapCount;
    logic [63:0] riseAddrs[$];

    // Shared comparison point.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        nCompared++;
        assert (observed === expected) else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Asynchronous reset applied between clock edges, outputs checked before
    // the next edge, released after one more edge.
    task automatic applyReset();
        #1;
        reset_n = 1'b0;
        branch_taken = 1'b0; trap = 1'b0; halt = 1'b0;
        imem_ack = 1'b0; instr_ready = 1'b0; imem_rdata = '0;
        #1;
        checkOutput("rst_req",      imem_req,     0);
        checkOutput("rst_addr",     imem_addr,    RV);
        checkOutput("rst_valid",    instr_valid,  0);
        checkOutput("rst_instr",    instr,        0);
        checkOutput("rst_instr_pc", instr_pc,     0);
        checkOutput("rst_epc",      epc,          0);
        checkOutput("rst_misalign", misalign_err, 0);
        checkOutput("rst_state",    state,        0);
        mPc = RV; mOut = 0; mStale = 0; mHolding = 0; mHalted = 0;
        mHaltPend = 0; mMis = 0; mEpc = '0; mDelivered = 0; gapCount = 0;
        riseAddrs.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // One clock cycle: drive inputs, advance the reference by the rules for
    // this cycle, clock the DUT, then compare.
    task automatic applyStimulus(input logic br, input logic [63:0] brT,
                                 input logic tr, input logic [63:0] trPc,
                                 input logic hl, input logic rdy, input logic ackW);
        logic        reqPrev, ackNow, redir, mis, stopReq;
        logic [63:0] addrPrev, tgt;
        branch_taken = br; branch_target = brT;
        trap = tr; trap_pc = trPc; halt = hl; instr_ready = rdy;
        imem_ack   = ackW && (imem_req === 1'b1);
        imem_rdata = $urandom;
        reqPrev  = imem_req;
        addrPrev = imem_addr;
        ackNow   = imem_ack;

        redir = tr || br;
        tgt   = tr ? TV : brT;
        mis   = redir && (tgt[1:0] != 2'b00);
        if (tr) mEpc = trPc;
        if (!mHalted) begin
            stopReq = hl || mHaltPend || mis;
            if (mis) mMis = 1;
            if (mHolding && ((mHolding && rdy) || redir || stopReq)) mHolding = 0;
            if (ackNow) begin
                mOut = 0;
                mHaltPend = 0;
                if (!mStale && !redir && !stopReq) begin
                    mHolding = 1; mInstr = imem_rdata; mInstrPc = mOutAddr;
                    mPc = mOutAddr + 64'd4; mDelivered++;
                end
            end else if (mOut) begin
                if (redir && !mis) mStale = 1;
                if (stopReq) mHaltPend = 1;
            end
            if (redir && !mis) mPc = tgt;
            if (stopReq && !mOut) begin
                mHalted = 1; mHolding = 0;
            end
        end

        @(posedge clk);
        #1;

        if (reqPrev && !ackNow) begin
            checkOutput("req_held",  imem_req,  1);
            checkOutput("addr_held", imem_addr, addrPrev);
        end
        if (reqPrev && ackNow) checkOutput("req_drop_after_ack", imem_req, 0);
        if (!reqPrev && imem_req === 1'b1) begin
            checkOutput("fetch_addr", imem_addr, mPc);
            riseAddrs.push_back(imem_addr);
            mOut = 1; mOutAddr = mPc; mStale = 0;
        end
        if (mHalted) checkOutput("halted_req", imem_req, 0);
        checkOutput("instr_valid", instr_valid, mHolding);
        if (mHolding) begin
            checkOutput("instr",    instr,    mInstr);
            checkOutput("instr_pc", instr_pc, mInstrPc);
        end
        checkOutput("epc",          epc,             mEpc);
        checkOutput("misalign_err", misalign_err,    mMis);
        checkOutput("halted_state", state === 2'b11, mHalted);
        if (!mHalted && !mHolding && imem_req !== 1'b1) gapCount++;
        else gapCount = 0;
        checkOutput("req_gap_len", gapCount < 2, 1);
    endtask

    logic        rBr, rTr, rHl, rRdy, rAck;
    logic [63:0] rT, rTp;
    int          totalDelivered;

    // Directed scenarios, then the randomized run.
    initial begin
        $display("[TB] start");
        applyReset();

        // Sequential fetch, ack on first request cycle, decode always ready.
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0, 0, 1, 1);
        checkOutput("seq_count",     riseAddrs.size(), 4);
        checkOutput("seq_addr0",     riseAddrs[0], 64'h0);
        checkOutput("seq_addr1",     riseAddrs[1], 64'h4);
        checkOutput("seq_addr2",     riseAddrs[2], 64'h8);
        checkOutput("seq_addr3",     riseAddrs[3], 64'hC);
        checkOutput("seq_delivered", mDelivered,   4);

        // Branch to 0x40 while the fetch of 0x8 is stalled three cycles.
        applyReset();
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0, 1, 1);
        applyStimulus(1, 64'h40, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkOutput("br_stall_addr", imem_addr, 64'h8);
        applyStimulus(0, 0, 0, 0, 0, 1, 1);
        checkOutput("br_drop_valid", instr_valid, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 1);
        checkOutput("br_new_addr",  imem_addr,  64'h40);
        checkOutput("br_delivered", mDelivered, 2);

        // Trap while decode stalls.
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("trap_pre_valid", instr_valid, 1);
        applyStimulus(0, 0, 1, 64'h24, 0, 0, 1);
        checkOutput("trap_valid", instr_valid, 0);
        checkOutput("trap_epc",   epc,         64'h24);
        checkOutput("trap_addr",  imem_addr,   64'h100);

        // Trap and branch together: trap wins.
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 64'h80, 1, 64'h104, 0, 0, 1);
        checkOutput("prio_addr", imem_addr, 64'h100);

        // Misaligned branch target halts with a sticky error.
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 64'h42, 0, 0, 0, 0, 1);
        checkOutput("mis_err",   misalign_err, 1);
        checkOutput("mis_state", state,        2'b11);
        applyStimulus(0, 0, 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 1);
        checkOutput("mis_req", imem_req, 0);
        applyReset();
        applyStimulus(0, 0, 0, 0, 0, 1, 1);
        checkOutput("mis_reset_addr", imem_addr, 64'h0);

        // PC wrap from the top of the address space, then reset mid-fetch.
        applyReset();
        applyStimulus(1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 1, 1);
        checkOutput("wrap_top", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        applyStimulus(0, 0, 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 1);
        checkOutput("wrap_zero", imem_addr, 64'h0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        applyReset();

        // Halt during an outstanding fetch waits for the ack.
        applyStimulus(0, 0, 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 1, 1, 0);
        checkOutput("halt_wait_state", state, 2'b01);
        applyStimulus(0, 0, 0, 0, 0, 1, 1);
        checkOutput("halt_fetch_state", state,       2'b11);
        checkOutput("halt_fetch_valid", instr_valid, 0);

        // Halt while an instruction waits at decode.
        applyReset();
        applyStimulus(0, 0, 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1, 0, 1);
        checkOutput("halt_hold_state", state,       2'b11);
        checkOutput("halt_hold_valid", instr_valid, 0);

        // Randomized run.
        applyReset();
        totalDelivered = 0;
        for (int i = 0; i < 1500; i++) begin
            if (mHalted && ($urandom_range(0, 2) == 0)) begin
                totalDelivered += mDelivered;
                applyReset();
            end
            rBr  = ($urandom_range(0, 11) == 0);
            rTr  = ($urandom_range(0, 29) == 0);
            rHl  = ($urandom_range(0, 299) == 0);
            rRdy = ($urandom_range(0, 2) != 0);
            rAck = ($urandom_range(0, 1) == 0);
            rT   = {$urandom, $urandom} & ~64'h3;
            if ($urandom_range(0, 39) == 0) rT[1:0] = 2'b10;
            rTp  = {$urandom, $urandom};
            applyStimulus(rBr, rT, rTr, rTp, rHl, rRdy, rAck);
        end
        totalDelivered += mDelivered;
        checkOutput("random_progress", totalDelivered > 100, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
